// File: rtl/case_7_prod_accum_if.sv
// rtl/case_7_prod_accum_if.sv - product-in / result-out handshake bundle for case_7_prod_accum
interface case_7_prod_accum_if #(
    parameter int DIN_WIDTH  = 14,
    parameter int DOUT_WIDTH = 16
);
    logic signed [DIN_WIDTH-1:0]  din;
    logic                         din_valid;
    logic                         din_ready;
    logic signed [DOUT_WIDTH-1:0] dout;
    logic                         dout_sat;
    logic                         dout_valid;
    logic                         dout_ready;

    modport master (
        output din, din_valid, dout_ready,
        input  din_ready, dout, dout_sat, dout_valid
    );

    modport slave (
        input  din, din_valid, dout_ready,
        output din_ready, dout, dout_sat, dout_valid
    );
endinterface

// File: rtl/case_7_prod_accum.sv
// rtl/case_7_prod_accum.sv - frame accumulator with shift/saturate rescale and registered output
// Optional round-half-up rescale enabled by defining CASE_7_PROD_ACCUM_ROUND_EN.
module case_7_prod_accum #(
    parameter int DIN_WIDTH  = 14,
    parameter int ACC_WIDTH  = 24,
    parameter int DOUT_WIDTH = 16,
    parameter int FRAME_LEN  = 8,
    parameter int SHIFT      = 4
) (
    input  logic ap_clk,
    input  logic ap_rst_n,
    case_7_prod_accum_if.slave bus
);

    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int EXT_W = ACC_WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

`ifdef CASE_7_PROD_ACCUM_ROUND_EN
    localparam int RB_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [EXT_W-1:0] ROUND_BIAS = (SHIFT > 0) ? (EXT_W'(1) << RB_SH) : '0;
`else
    localparam logic signed [EXT_W-1:0] ROUND_BIAS = '0;
`endif

    localparam logic signed [EXT_W-1:0] SAT_MAX = (EXT_W'(1) << (DOUT_WIDTH - 1)) - EXT_W'(1);
    localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic {S_ACC, S_OUT} state_t;

    state_t                        state, state_nxt;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic        [CNT_W-1:0]       cnt;
    logic signed [ACC_WIDTH-1:0]   din_ext;
    logic signed [ACC_WIDTH-1:0]   sum;
    logic signed [EXT_W-1:0]       biased;
    logic signed [EXT_W-1:0]       shifted;
    logic signed [DOUT_WIDTH-1:0]  res;
    logic                          res_sat;
    logic                          rdy;
    logic                          beat;
    logic                          xfer;
    logic                          last;

    always_comb begin
        rdy       = 1'b1;
        state_nxt = state;
        case (state)
            S_ACC:   rdy = 1'b1;
            S_OUT:   rdy = bus.dout_ready;
            default: rdy = 1'b1;
        endcase
        beat = bus.din_valid && rdy;
        xfer = (state == S_OUT) && bus.dout_ready;
        last = (cnt == LAST_CNT);
        if (xfer)
            state_nxt = S_ACC;
        // A final beat wins over the transfer so FRAME_LEN==1 stays in S_OUT.
        if (beat && last)
            state_nxt = S_OUT;
    end

    assign bus.din_ready = rdy;

    // After a result is registered acc/cnt are already zero, so a beat taken
    // during the output transfer naturally starts the next frame.
    always_comb begin
        din_ext = $signed({{(ACC_WIDTH-DIN_WIDTH){bus.din[DIN_WIDTH-1]}}, bus.din});
        sum     = acc + din_ext;
        biased  = EXT_W'(sum) + ROUND_BIAS;
        shifted = biased >>> SHIFT;
        res     = shifted[DOUT_WIDTH-1:0];
        res_sat = 1'b0;
        if (shifted > SAT_MAX) begin
            res     = SAT_MAX[DOUT_WIDTH-1:0];
            res_sat = 1'b1;
        end else if (shifted < SAT_MIN) begin
            res     = SAT_MIN[DOUT_WIDTH-1:0];
            res_sat = 1'b1;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state          <= S_ACC;
            acc            <= '0;
            cnt            <= '0;
            bus.dout       <= '0;
            bus.dout_sat   <= 1'b0;
            bus.dout_valid <= 1'b0;
        end else begin
            state          <= state_nxt;
            bus.dout_valid <= (state_nxt == S_OUT);
            if (beat) begin
                if (last) begin
                    acc          <= '0;
                    cnt          <= '0;
                    bus.dout     <= res;
                    bus.dout_sat <= res_sat;
                end else begin
                    acc <= sum;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_case_7_prod_accum.sv
// tb/tb_case_7_prod_accum.sv - bench for case_7_prod_accum (default SHIFT=4 and SHIFT=0 instances)
module tb_case_7_prod_accum;

`ifdef CASE_7_PROD_ACCUM_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif
    localparam int FL = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    case_7_prod_accum_if #(.DIN_WIDTH(14), .DOUT_WIDTH(16)) b0 ();
    case_7_prod_accum_if #(.DIN_WIDTH(14), .DOUT_WIDTH(16)) b1 ();

    assign b1.din        = b0.din;
    assign b1.din_valid  = b0.din_valid;
    assign b1.dout_ready = b0.dout_ready;

    case_7_prod_accum dut0 (.ap_clk(clk), .ap_rst_n(rst_n), .bus(b0));
    case_7_prod_accum #(.SHIFT(0)) dut1 (.ap_clk(clk), .ap_rst_n(rst_n), .bus(b1));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        longint d;
        bit     s;
    } res_t;

    // Reference rescale: add bias, floor-divide by 2^sh, clip to 16-bit signed.
    function automatic res_t calc(input longint s, input int sh);
        res_t   r;
        longint bias;
        longint q;
        bias = (RND && sh > 0) ? (64'sd1 <<< (sh - 1)) : 64'sd0;
        q    = (s + bias) >>> sh;
        r.s  = 1'b0;
        r.d  = q;
        if (q > 32767)  begin r.d = 32767;  r.s = 1'b1; end
        if (q < -32768) begin r.d = -32768; r.s = 1'b1; end
        return r;
    endfunction

    // Scoreboard: frame bookkeeping in plain integers.
    bit     chk_en = 1'b0;
    bit     m_pend;
    longint m_sum;
    int     m_cnt;
    res_t   m_exp0, m_exp1;
    wire    m_beat = b0.din_valid && (!m_pend || b0.dout_ready);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend <= 1'b0;
            m_sum  <= 0;
            m_cnt  <= 0;
        end else begin
            if (m_pend && b0.dout_ready)
                m_pend <= 1'b0;
            if (m_beat) begin
                if (m_cnt == FL - 1) begin
                    m_exp0 <= calc(m_sum + longint'(b0.din), 4);
                    m_exp1 <= calc(m_sum + longint'(b0.din), 0);
                    m_pend <= 1'b1;
                    m_sum  <= 0;
                    m_cnt  <= 0;
                end else begin
                    m_sum <= m_sum + longint'(b0.din);
                    m_cnt <= m_cnt + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("sb_valid0", b0.dout_valid, m_pend);
            chk("sb_valid1", b1.dout_valid, m_pend);
            chk("sb_ready", b0.din_ready, !m_pend || b0.dout_ready);
            if (m_pend) begin
                chk("sb_dout0", b0.dout, m_exp0.d);
                chk("sb_sat0", b0.dout_sat, m_exp0.s);
                chk("sb_dout1", b1.dout, m_exp1.d);
                chk("sb_sat1", b1.dout_sat, m_exp1.s);
            end
        end
    end

    typedef struct {
        int din;
        int e_main;
        bit s_main;
        int e_s0;
        bit s_s0;
    } vec_t;

    vec_t vt[7];

    task automatic run_frame(input vec_t v, input string tag);
        for (int i = 0; i < FL; i++) begin
            b0.din        = 14'(v.din);
            b0.din_valid  = 1'b1;
            b0.dout_ready = 1'b1;
            @(posedge clk);
            #1;
            chk({tag, "_valid_timing"}, b0.dout_valid, (i == FL - 1));
        end
        b0.din_valid = 1'b0;
        chk({tag, "_dout"}, b0.dout, v.e_main);
        chk({tag, "_sat"}, b0.dout_sat, v.s_main);
        chk({tag, "_dout_s0"}, b1.dout, v.e_s0);
        chk({tag, "_sat_s0"}, b1.dout_sat, v.s_s0);
        @(posedge clk);
        #1;
        chk({tag, "_valid_drop"}, b0.dout_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{din: 100,   e_main: 50,             s_main: 0, e_s0: 800,    s_s0: 0};
        vt[1] = '{din: 1,     e_main: RND ? 1 : 0,    s_main: 0, e_s0: 8,      s_s0: 0};
        vt[2] = '{din: -1,    e_main: RND ? 0 : -1,   s_main: 0, e_s0: -8,     s_s0: 0};
        vt[3] = '{din: 8191,  e_main: RND ? 4096 : 4095, s_main: 0, e_s0: 32767, s_s0: 1};
        vt[4] = '{din: -8192, e_main: -4096,          s_main: 0, e_s0: -32768, s_s0: 1};
        vt[5] = '{din: 4095,  e_main: RND ? 2048 : 2047, s_main: 0, e_s0: 32760, s_s0: 0};
        vt[6] = '{din: 16,    e_main: 8,              s_main: 0, e_s0: 128,    s_s0: 0};

        b0.din        = '0;
        b0.din_valid  = 1'b0;
        b0.dout_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst_valid", b0.dout_valid, 0);
        chk("rst_dout", b0.dout, 0);
        chk("rst_sat", b0.dout_sat, 0);
        chk("rst_ready", b0.din_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", b0.din_ready, 1);

        for (int k = 0; k < 7; k++)
            run_frame(vt[k], $sformatf("vec%0d", k));

        // Backpressure: hold the result five cycles with din_valid asserted.
        for (int i = 0; i < FL; i++) begin
            b0.din = 14'(100); b0.din_valid = 1'b1; b0.dout_ready = 1'b0;
            @(posedge clk);
            #1;
        end
        b0.din = 14'(7);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", b0.dout_valid, 1);
            chk("bp_dout", b0.dout, 50);
            chk("bp_sat", b0.dout_sat, 0);
            chk("bp_ready", b0.din_ready, 0);
            @(posedge clk);
            #1;
        end
        b0.dout_ready = 1'b1;
        #1;
        chk("bp_ready_comb", b0.din_ready, 1);
        for (int i = 0; i < FL; i++) begin
            @(posedge clk);
            #1;
            chk("bp_next_valid", b0.dout_valid, (i == FL - 1));
        end
        b0.din_valid = 1'b0;
        chk("bp_next_dout", b0.dout, RND ? 4 : 3);
        chk("bp_next_dout_s0", b1.dout, 56);
        @(posedge clk);
        #1;

        // Back-to-back: three frames with no bubble.
        for (int i = 0; i < 3 * FL; i++) begin
            b0.din = 14'(16); b0.din_valid = 1'b1; b0.dout_ready = 1'b1;
            chk("b2b_ready", b0.din_ready, 1);
            @(posedge clk);
            #1;
            chk("b2b_valid", b0.dout_valid, ((i % FL) == FL - 1));
            if ((i % FL) == FL - 1) begin
                chk("b2b_dout", b0.dout, 8);
                chk("b2b_dout_s0", b1.dout, 128);
            end
        end
        b0.din_valid = 1'b0;
        @(posedge clk);
        #1;

        // Reset in the middle of a frame discards the partial sum.
        for (int i = 0; i < 3; i++) begin
            b0.din = 14'(500); b0.din_valid = 1'b1; b0.dout_ready = 1'b1;
            @(posedge clk);
            #1;
        end
        b0.din_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", b0.dout_valid, 0);
        chk("mid_rst_dout", b0.dout, 0);
        chk("mid_rst_sat", b0.dout_sat, 0);
        chk("mid_rst_ready", b0.din_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("after_rst_valid", b0.dout_valid, 0);
        chk("after_rst_dout", b0.dout, 0);
        chk("after_rst_ready", b0.din_ready, 1);
        run_frame(vt[0], "after_rst");

        // Randomised traffic, scoreboard-checked.
        for (int i = 0; i < 3000; i++) begin
            case ($urandom % 6)
                0:       b0.din = 14'(8191);
                1:       b0.din = 14'(-8192);
                default: b0.din = 14'($urandom);
            endcase
            b0.din_valid  = ($urandom % 4) != 0;
            b0.dout_ready = ($urandom % 3) != 0;
            @(posedge clk);
            #1;
        end
        b0.din_valid = 1'b0;
        b0.dout_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/case_7_prod_accum.md
# case_7_prod_accum

Downstream consumer of the signed 14-bit product stream from the case_7 signed multiplier stage. It accumulates a fixed-length frame of products with full precision, then rescales the sum. Rescaling is an arithmetic right shift with optional rounding, followed by saturation to the output width. The result is presented on a registered valid/ready output with backpressure to the multiplier-side producer.

## Interface
- DIN_WIDTH, 14: width of signed product input.
- ACC_WIDTH, 24: accumulator width. Must be ≥ DIN_WIDTH + clog2(FRAME_LEN); otherwise wrap behaviour is undefined.
- DOUT_WIDTH, 16: width of signed saturated result.
- FRAME_LEN, 8: products per frame, ≥ 1.
- SHIFT, 4: right-shift applied to the frame sum, 0 ≤ SHIFT < ACC_WIDTH.

- ap_clk  input  1  sole clock, rising edge.
- ap_rst_n  input  1  asynchronous, active-low reset.
- din  input  DIN_WIDTH  signed product from multiplier.
- din_valid  input  1  din carries a product.
- din_ready  output  1  block accepts din this cycle.
- dout  output  DOUT_WIDTH  signed rescaled frame result, registered.
- dout_sat  output  1  dout was clipped, registered alongside dout.
- dout_valid  output  1  dout/dout_sat valid.
- dout_ready  input  1  consumer takes dout this cycle.

## Operation
- Beat: din_valid && din_ready at a rising edge. Output transfer: dout_valid && dout_ready.
- Two-state FSM:
  - S_ACC: din_ready=1. Each beat adds sign-extended din into acc and increments cnt.
    - On beat with cnt==FRAME_LEN-1: compute final = acc + din, register result, clear acc and cnt, go to S_OUT.
  - S_OUT: dout_valid=1. din_ready = dout_ready.
    - Output transfer without a simultaneous beat: go to S_ACC.
    - Output transfer with a simultaneous beat: that beat is the first product of the next frame. Go to S_ACC with acc=din, cnt=1. If FRAME_LEN==1, stay in S_OUT with the new result instead.
    - No output transfer: dout, dout_sat, dout_valid held stable. No beat is accepted.
- Rescale: r = final + ROUND_BIAS, then arithmetic right shift by SHIFT (sign-preserving floor).
- Saturate r to [−2^(DOUT_WIDTH−1), 2^(DOUT_WIDTH−1)−1]. dout_sat=1 iff clipping occurred.
- Internal intermediate sum is ACC_WIDTH+1 bits so the rounding bias cannot overflow.
- din is ignored when din_valid=0. dout_ready is ignored in S_ACC.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): state=S_ACC, acc=0, cnt=0, dout=0, dout_sat=0, dout_valid=0. din_ready=1 from the first cycle after reset deassert.
- Reset mid-frame or mid-hold discards the partial sum and any pending result.
- Latency: dout_valid rises the cycle after the final beat of a frame is accepted.
- Throughput: one product per cycle, including back-to-back frames when dout_ready=1 continuously. There is no bubble between frames.
- din_ready is combinational from state and dout_ready. There is no combinational path from din_valid to din_ready or from din to any output.

## Configuration
- Macro CASE_7_PROD_ACCUM_ROUND_EN:
  - Defined: ROUND_BIAS = 2^(SHIFT−1) when SHIFT>0, giving round-half-up toward +∞.
  - Undefined: ROUND_BIAS = 0, giving truncation (floor).
  - SHIFT=0 is identical in both builds.

## Test plan
- Basic frame: defaults, 8 beats din=100, dout_ready=1 → dout=50, dout_sat=0; dout_valid high exactly one cycle, one cycle after the 8th beat.
- Rounding: 8 beats din=1 → dout=1 with macro, 0 without. 8 beats din=−1 → dout=0 with macro, −1 without.
- Saturation, SHIFT=0 override:
  - 8 beats din=8191 → dout=32767, dout_sat=1.
  - 8 beats din=−8192 → dout=−32768, dout_sat=1.
  - 8 beats din=4095 → dout=32760, dout_sat=0.
- Backpressure: dout_ready=0 for 5 cycles after a frame → dout_valid, dout, dout_sat stable and din_ready=0 throughout. Raise dout_ready with din_valid=1 → the product is accepted that same cycle as beat 1 of the next frame, and that frame's result is correct.
- Back-to-back: 24 continuous beats din=16, dout_ready=1 → three results of 8, each one cycle after beats 8, 16, 24; din_ready never drops.
- Reset mid-frame: 3 beats din=500, pulse ap_rst_n low for 1 cycle, then 8 beats din=100 → dout=50; all outputs read reset values during and immediately after reset.
